// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------------+
// | aes_pkg: shared AES widths, decrypt-stage FSM encoding, inverse S-box.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

    localparam int AES_STATE_W   = 128;
    localparam int AES_WORD_W    = 32;
    localparam int AES_NUM_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

`default_nettype wire

// File: rtl/aes_inv_sbox.sv
// +----------------------------------------------------------------------------+
// | aes_inv_sbox: single-byte AES inverse substitution (table lookup).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = INV_SBOX[i_byte];

endmodule

`default_nettype wire

// File: rtl/aes_inv_sub_word.sv
// +----------------------------------------------------------------------------+
// | aes_inv_sub_word: combinational InvSubWord, four byte lanes, no rotation.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_inv_sub_word
    import aes_pkg::*;
(
    input  logic [AES_WORD_W-1:0] i_word,
    output logic [AES_WORD_W-1:0] o_word
);

    // Byte 0 sits in the most significant position, matching state ordering.
    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_inv_sbox u_inv_sbox (
            .i_byte (i_word[AES_WORD_W-1-8*b -: 8]),
            .o_byte (o_word[AES_WORD_W-1-8*b -: 8])
        );
    end

endmodule

`default_nettype wire

// File: rtl/aes_inv_sub_bytes_seq.sv
// +----------------------------------------------------------------------------+
// | aes_inv_sub_bytes_seq: word-serial InvSubBytes, LANES words per clock.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int CNT_W = $clog2(AES_NUM_WORDS);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("aes_inv_sub_bytes_seq: LANES must be 1, 2 or 4");
    end

    aes_fsm_e               state_q, state_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [CNT_W-1:0]      lane_idx [LANES];
    logic [AES_WORD_W-1:0] lane_in  [LANES];
    logic [AES_WORD_W-1:0] lane_out [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = cnt_q + CNT_W'(l);
        assign lane_in[l]  = work_q[(AES_STATE_W-1) - AES_WORD_W*int'(lane_idx[l]) -: AES_WORD_W];

        aes_inv_sub_word u_inv_sub_word (
            .i_word (lane_in[l]),
            .o_word (lane_out[l])
        );
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[(AES_STATE_W-1) - AES_WORD_W*int'(lane_idx[l]) -: AES_WORD_W] = lane_out[l];
                end
                // The counter wraps to zero naturally once the last word is done.
                cnt_d = cnt_q + CNT_W'(LANES);
                if (lane_idx[LANES-1] == CNT_W'(AES_NUM_WORDS-1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs come only from the state register; data is gated so
    // partially substituted words never leak out.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = out_valid ? work_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// +----------------------------------------------------------------------------+
// | tb_aes_inv_sub_bytes_seq: directed and round-trip bench, LANES 1/2/4.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_aes_inv_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   busy;
    logic         out_ready;
    logic [127:0] in_state;
    logic [127:0] out_state [3];

    int checks = 0;
    int errors = 0;
    int xfers = 0;
    int exp_xfers = 0;

    always #5 clk = ~clk;

    aes_inv_sub_bytes_seq #(.LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_state(out_state[0]),
        .busy(busy[0])
    );
    aes_inv_sub_bytes_seq #(.LANES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_state(out_state[1]),
        .busy(busy[1])
    );
    aes_inv_sub_bytes_seq #(.LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_state(in_state),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_state(out_state[2]),
        .busy(busy[2])
    );

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (out_valid[k] && out_ready) xfers <= xfers + 1;
        end
    end

    localparam logic [7:0] FWD_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] fwd_sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[31-8*b -: 8] = FWD_SBOX[w[31-8*b -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] fwd_sub_bytes(input logic [127:0] s);
        return {fwd_sub_word(s[127:96]), fwd_sub_word(s[95:64]),
                fwd_sub_word(s[63:32]), fwd_sub_word(s[31:0])};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents s to instance k, steps through the acceptance edge and then
    // counts clocks until out_valid rises (bounded).
    task automatic run_block(input int k, input logic [127:0] s, input bit chk_run, output int lat);
        int n;
        in_state    = s;
        in_valid[k] = 1'b1;
        n = 0;
        while (!in_ready[k] && n < 20) begin
            step;
            n++;
        end
        check("accept_ready", 128'(in_ready[k]), 128'd1);
        step;
        in_valid[k] = 1'b0;
        in_state    = ~s;
        if (chk_run && k == 0) begin
            check("run_in_ready", 128'(in_ready[k]), 128'd0);
            check("run_busy", 128'(busy[k]), 128'd1);
            check("run_out_gated", out_state[k], 128'd0);
        end
        lat = 0;
        while (!out_valid[k] && lat < 20) begin
            step;
            lat++;
        end
        check("out_valid_rise", 128'(out_valid[k]), 128'd1);
    endtask

    localparam logic [127:0] V63  = 128'h63636363_63636363_63636363_63636363;
    localparam logic [127:0] V52  = 128'h52525252_52525252_52525252_52525252;
    localparam logic [127:0] VMIX = 128'h637c7777_ff16ff16_00000000_7c637c63;
    localparam logic [127:0] EMIX = 128'h00010202_7dff7dff_52525252_01000100;
    localparam logic [127:0] V16  = 128'h16161616_16161616_16161616_16161616;
    localparam logic [127:0] VFF  = 128'hffffffff_ffffffff_ffffffff_ffffffff;

    initial begin
        int lat;
        int k;
        bit got;
        logic [127:0] orig;

        in_valid  = 3'b000;
        out_ready = 1'b0;
        in_state  = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 128'(in_ready[i]), 128'd1);
            check("rst_out_valid", 128'(out_valid[i]), 128'd0);
            check("rst_out_state", out_state[i], 128'd0);
            check("rst_busy", 128'(busy[i]), 128'd0);
        end
        rst_n = 1'b1;
        step;

        // All-0x63 state inverts to zero; LANES=1 takes four clocks.
        out_ready = 1'b1;
        run_block(0, V63, 1'b1, lat);
        check("lat_l1_63", 128'(lat), 128'd4);
        check("data_63", out_state[0], 128'd0);
        step;
        exp_xfers++;
        check("post_xfer_valid", 128'(out_valid[0]), 128'd0);
        check("post_xfer_ready", 128'(in_ready[0]), 128'd1);

        // Zero state on every lane count, latency 4/LANES.
        for (int i = 0; i < 3; i++) begin
            run_block(i, 128'd0, 1'b0, lat);
            check("lat_zero", 128'(lat), 128'(4 >> i));
            check("data_zero", out_state[i], V52);
            step;
            exp_xfers++;
        end

        // Mixed vector pins down word and byte ordering.
        for (int i = 0; i < 3; i++) begin
            run_block(i, VMIX, 1'b0, lat);
            check("data_mix", out_state[i], EMIX);
            step;
            exp_xfers++;
        end

        // Back-pressure with a competing in_valid that must be ignored.
        out_ready = 1'b0;
        run_block(0, VMIX, 1'b0, lat);
        in_valid[0] = 1'b1;
        in_state    = V63;
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 128'(out_valid[0]), 128'd1);
            check("stall_data", out_state[0], EMIX);
            check("stall_in_ready", 128'(in_ready[0]), 128'd0);
            step;
        end
        in_valid[0] = 1'b0;
        out_ready   = 1'b1;
        step;
        exp_xfers++;
        check("bp_release_ready", 128'(in_ready[0]), 128'd1);
        check("bp_release_valid", 128'(out_valid[0]), 128'd0);
        check("bp_release_data", out_state[0], 128'd0);
        check("bp_single_xfer", 128'(xfers), 128'(exp_xfers));

        // Reset after two words of a LANES=1 block aborts it.
        in_state    = VMIX;
        in_valid[0] = 1'b1;
        step;
        in_valid[0] = 1'b0;
        step;
        step;
        check("pre_abort_busy", 128'(busy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 128'(out_valid[0]), 128'd0);
        check("abort_data", out_state[0], 128'd0);
        check("abort_busy", 128'(busy[0]), 128'd0);
        check("abort_ready", 128'(in_ready[0]), 128'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step;
        run_block(0, V16, 1'b0, lat);
        check("lat_after_rst", 128'(lat), 128'd4);
        check("data_16", out_state[0], VFF);
        step;
        exp_xfers++;

        // Round trip through a reference forward SubBytes with random gaps.
        for (int i = 0; i < 1000; i++) begin
            k    = i % 3;
            orig = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) step;
            run_block(k, fwd_sub_bytes(orig), 1'b0, lat);
            got = 1'b0;
            for (int n = 0; n < 40 && !got; n++) begin
                out_ready = (n > 10) ? 1'b1 : 1'($urandom_range(0, 1));
                if (out_valid[k] && out_ready) begin
                    check("roundtrip", out_state[k], orig);
                    got = 1'b1;
                end
                step;
            end
            if (!got) check("roundtrip_timeout", 128'd0, 128'd1);
            exp_xfers++;
        end

        step;
        check("xfer_count", 128'(xfers), 128'(exp_xfers));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
